dma_engine: RTL and testbench
=============================

DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 Parameter NCH, default 2, number of independent copy channels (1..8).
REQ-002 Parameter AW, default 16, SRAM address width in bits.
REQ-003 Parameter DW, default 32, SRAM data width in bits.
REQ-004 Parameter LW, default 16, transfer-length counter width in bits.
REQ-005 Port clk  in  1  clock; all state changes on its rising edge.
REQ-006 Port reset  in  1  reset, synchronous, active-high.
REQ-007 Port cfg_valid  in  1  copy request strobe.
REQ-008 Port cfg_ready  out  1  request accepted when cfg_valid and cfg_ready are both high on an edge.
REQ-009 Port cfg_ch  in  clog2(NCH) (min 1)  target channel.
REQ-010 Ports cfg_src, cfg_dst  in  AW  source and destination word addresses; cfg_len  in  LW  word count.
REQ-011 Port poll_ch  in  clog2(NCH); poll_len  out  LW  combinational remaining word count of poll_ch.
REQ-012 Port busy  out  NCH  per-channel active flag; done  out  NCH  one-cycle completion pulse.
REQ-013 Port cpu_req  in  1  CPU owns SRAM this cycle; DMA SHALL yield.
REQ-014 Ports mem_en, mem_we  out  1; mem_addr  out  AW; mem_di  out  DW; mem_do  in  DW (valid the cycle after a read enable).

Function
REQ-015 cfg_ready SHALL equal !busy[cfg_ch]; requests to a busy channel are not accepted and have no effect.
REQ-016 On acceptance with cfg_len>0: channel loads src/dst/len, busy[ch]=1 from the next cycle.
REQ-017 On acceptance with cfg_len=0: busy stays 0; done[ch] pulses the next cycle.
REQ-018 Datapath FSM states ARB, RD, CAP, WR; SHALL move one word per pass, 4 cycles per word uncontended.
REQ-019 ARB: round-robin selection among busy channels, search starting at last-served+1 mod NCH; none busy -> stay in ARB.
REQ-020 RD: mem_en=1, mem_we=0, mem_addr=src of selected channel -> CAP.
REQ-021 CAP: register mem_do into the data buffer; no SRAM access -> WR.
REQ-022 WR: mem_en=1, mem_we=1, mem_addr=dst, mem_di=buffer; same edge src+1, dst+1, len-1 -> ARB.
REQ-023 When len reaches 0 in WR: busy[ch] clears and done[ch] pulses the next cycle.
REQ-024 In RD or WR with cpu_req=1: mem_en=0 and state holds; access is issued on the first cycle with cpu_req=0.
REQ-025 Outside RD/WR issue cycles: mem_en=0, mem_we=0, mem_addr=0, mem_di=0.
REQ-026 Address increment SHALL wrap modulo 2^AW; overlapping ranges copy in ascending order with no hazard protection.
REQ-027 A request to an idle channel on the edge where another channel is in WR SHALL be accepted; a channel finishing on that edge is not ready until the next cycle.

Reset
REQ-028 While reset is high on an edge: FSM to ARB, all busy/done/len/src/dst/buffer and round-robin pointer to 0, mem_en=mem_we=0; in-flight transfers are dropped with no done pulse.

Configuration
REQ-029 Macro DMA_ENGINE_ABORT_EN defined: adds ports abort_valid in 1 and abort_ch in clog2(NCH); abort_valid high on an edge clears len and busy of abort_ch with no done pulse; if that channel is selected in RD/CAP/WR, the pending write is suppressed and FSM returns to ARB; abort takes priority over a same-edge cfg to that channel.
REQ-030 Macro undefined: abort ports absent; transfers run only to completion or reset.

Verification
REQ-031 ch0 src=0x10 dst=0x40 len=3, cpu_req=0 -> SRAM[0x40..0x42]=SRAM[0x10..0x12], done[0] pulse 12 cycles after acceptance edge +1.
REQ-032 ch0 len=2 and ch1 len=2 accepted same cycle order -> words serviced ch0,ch1,ch0,ch1; both done within 16 cycles.
REQ-033 cpu_req held high 5 cycles during RD -> mem_en low those cycles, copy completes correct, 5 cycles later.
REQ-034 src=0xFFFF dst=0x0100 len=2 -> reads 0xFFFF then 0x0000; poll_len reads 2,1,0 across transfer.
REQ-035 cfg_len=0 -> busy[ch] stays 0, done[ch] pulses next cycle; request to busy channel -> cfg_ready=0, state unchanged.
REQ-036 reset asserted mid-copy (len=4 remaining 2) -> busy=0, poll_len=0, no done, no further mem_en; with DMA_ENGINE_ABORT_EN, abort during CAP -> no write issued, busy clears next cycle.

Source files
------------

// File: rtl/dma_engine.sv
// dma_engine: multi-channel SRAM-to-SRAM word copier.
//
// Each of NCH channels holds a (src, dst, len) descriptor. One shared datapath
// FSM (ARB -> RD -> CAP -> WR) moves a single word per pass. Busy channels are
// served round-robin. The CPU has priority on the SRAM: while cpu_req is high,
// a pending RD or WR access waits.
//
// Optional feature: define DMA_ENGINE_ABORT_EN to add abort_valid/abort_ch.
// An abort cancels a channel with no done pulse.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   cfg_valid/cfg_ready   copy request handshake; cfg_ready = !busy[cfg_ch]
//   cfg_ch, cfg_src, cfg_dst, cfg_len   request target channel and descriptor
//   poll_ch / poll_len    combinational read of the remaining word count
//   busy, done            per-channel active flag and one-cycle completion pulse
//   cpu_req               the CPU owns the SRAM this cycle
//   mem_en, mem_we, mem_addr, mem_di, mem_do   SRAM port (read data one cycle late)
//   abort_valid, abort_ch (DMA_ENGINE_ABORT_EN only)   channel cancel
module dma_engine #(
  parameter int NCH = 2,
  parameter int AW  = 16,
  parameter int DW  = 32,
  parameter int LW  = 16,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [AW-1:0]  cfg_src,
  input  logic [AW-1:0]  cfg_dst,
  input  logic [LW-1:0]  cfg_len,
  input  logic [CW-1:0]  poll_ch,
  output logic [LW-1:0]  poll_len,
`ifdef DMA_ENGINE_ABORT_EN
  input  logic           abort_valid,
  input  logic [CW-1:0]  abort_ch,
`endif
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done,
  input  logic           cpu_req,
  output logic           mem_en,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_di,
  input  logic [DW-1:0]  mem_do
);

  typedef enum logic [1:0] {ARB, RD, CAP, WR} state_t;

  // Channel indices are widened by one bit so range checks also work when NCH
  // is not a power of two.
  localparam logic [CW:0] NCH_C = (CW+1)'(NCH);

  state_t          state_q, state_d;
  logic [CW-1:0]   sel_q, sel_d;   // channel owning the datapath
  logic [CW-1:0]   rr_q, rr_d;     // round-robin search start (last served + 1)
  logic [DW-1:0]   buf_q, buf_d;
  logic [AW-1:0]   src_q [NCH];
  logic [AW-1:0]   src_d [NCH];
  logic [AW-1:0]   dst_q [NCH];
  logic [AW-1:0]   dst_d [NCH];
  logic [LW-1:0]   len_q [NCH];
  logic [LW-1:0]   len_d [NCH];
  logic [NCH-1:0]  busy_q, busy_d;
  logic [NCH-1:0]  done_q, done_d;

  logic            found;
  logic [CW-1:0]   pick, cand;
  logic            abort_hit;
  logic [CW-1:0]   abort_ch_w;

`ifdef DMA_ENGINE_ABORT_EN
  assign abort_hit  = abort_valid && ({1'b0, abort_ch} < NCH_C);
  assign abort_ch_w = abort_ch;
`else
  assign abort_hit  = 1'b0;
  assign abort_ch_w = '0;
`endif

  assign cfg_ready = ({1'b0, cfg_ch} < NCH_C) && !busy_q[cfg_ch];
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    poll_len = '0;
    if ({1'b0, poll_ch} < NCH_C) poll_len = len_q[poll_ch];
  end

  // Round-robin pick: first busy channel at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = CW'((int'(rr_q) + k) % NCH);
      if (!found && busy_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    buf_d    = buf_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    busy_d   = busy_q;
    done_d   = '0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;

    unique case (state_q)
      ARB: if (found) begin
        sel_d   = pick;
        rr_d    = (pick == CW'(NCH-1)) ? '0 : pick + CW'(1);
        state_d = RD;
      end
      RD: if (!cpu_req) begin
        mem_en   = 1'b1;
        mem_addr = src_q[sel_q];
        state_d  = CAP;
      end
      CAP: begin
        buf_d   = mem_do;
        state_d = WR;
      end
      WR: if (!cpu_req) begin
        mem_en        = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = dst_q[sel_q];
        mem_di        = buf_q;
        src_d[sel_q]  = src_q[sel_q] + AW'(1);
        dst_d[sel_q]  = dst_q[sel_q] + AW'(1);
        len_d[sel_q]  = len_q[sel_q] - LW'(1);
        if (len_q[sel_q] == LW'(1)) begin
          busy_d[sel_q] = 1'b0;
          done_d[sel_q] = 1'b1;
        end
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase

    // New descriptors only land on idle channels, so they never collide with
    // the datapath's update of the selected (busy) channel.
    if (cfg_valid && cfg_ready && !(abort_hit && abort_ch_w == cfg_ch)) begin
      if (cfg_len != '0) begin
        src_d[cfg_ch]  = cfg_src;
        dst_d[cfg_ch]  = cfg_dst;
        len_d[cfg_ch]  = cfg_len;
        busy_d[cfg_ch] = 1'b1;
      end else begin
        done_d[cfg_ch] = 1'b1;
      end
    end

    // Abort wins over everything for its channel, including a completion on
    // the same edge, and kills any access the datapath is issuing for it.
    if (abort_hit) begin
      len_d[abort_ch_w]  = '0;
      busy_d[abort_ch_w] = 1'b0;
      done_d[abort_ch_w] = 1'b0;
      if (state_q != ARB && sel_q == abort_ch_w) begin
        state_d  = ARB;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_di   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      sel_q   <= '0;
      rr_q    <= '0;
      buf_q   <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        src_q[c] <= '0;
        dst_q[c] <= '0;
        len_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int c = 0; c < NCH; c++) begin
        src_q[c] <= src_d[c];
        dst_q[c] <= dst_d[c];
        len_q[c] <= len_d[c];
      end
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
module tb_dma_engine;
  localparam int NCH = 2;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LW  = 16;
  localparam int CW  = 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch = '0;
  logic [AW-1:0]  cfg_src = '0;
  logic [AW-1:0]  cfg_dst = '0;
  logic [LW-1:0]  cfg_len = '0;
  logic [CW-1:0]  poll_ch = '0;
  logic [LW-1:0]  poll_len;
  logic [NCH-1:0] busy, done;
  logic           cpu_req = 1'b0;
  logic           mem_en, mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_di;
  logic [DW-1:0]  mem_do;
`ifdef DMA_ENGINE_ABORT_EN
  logic           abort_valid = 1'b0;
  logic [CW-1:0]  abort_ch = '0;
`endif

  dma_engine #(.NCH(NCH), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .poll_ch(poll_ch), .poll_len(poll_len),
`ifdef DMA_ENGINE_ABORT_EN
    .abort_valid(abort_valid), .abort_ch(abort_ch),
`endif
    .busy(busy), .done(done), .cpu_req(cpu_req),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  // SRAM model: sources always return a fixed address-derived pattern,
  // writes are stored for later inspection.
  logic [DW-1:0] sram [65536];
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16'h5A00, a};
  endfunction
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr] <= mem_di;
    if (mem_en && !mem_we) mem_do <= pat(mem_addr);
  end

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int plen [64];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every SRAM write is matched in order against the scoreboard.
  always @(negedge clk) begin : mon
    wr_t e;
    #2;
    if (cpu_req) begin
      checks++;
      if (mem_en) begin
        errors++;
        $display("FAIL cpu_yield mem_en=%0b exp=0", mem_en);
      end
    end
    if (mem_en && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_di);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.a || mem_di !== e.d) begin
          errors++;
          $display("FAIL write addr=%h data=%h exp addr=%h data=%h", mem_addr, mem_di, e.a, e.d);
        end
      end
    end
  end

  task automatic do_cfg(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [LW-1:0] l, input logic exp_rdy, input string nm);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_ch = CW'(ch);
    cfg_src = s;
    cfg_dst = d;
    cfg_len = l;
    #1;
    chk({nm, "_rdy"}, 32'(cfg_ready), 32'(exp_rdy));
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  // Counts cycles after the last acceptance edge until done[ch]; optionally
  // holds cpu_req high for cycles s0..s1-1. Logs poll_len per cycle.
  task automatic wait_done(input int ch, input int exp_n, input int s0, input int s1, input string nm);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      cpu_req = (n >= s0 && n < s1);
      #2;
      plen[n] = int'(poll_len);
      if (done[ch]) seen = 1'b1;
    end
    cpu_req = 1'b0;
    chk({nm, "_done_cyc"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n0, n1, bad;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_poll_len", 32'(poll_len), 0);

    // Basic 3-word copy: done pulse 13 cycles after the acceptance edge.
    push_wr(16'h0040, 32'h5A00_0010);
    push_wr(16'h0041, 32'h5A00_0011);
    push_wr(16'h0042, 32'h5A00_0012);
    do_cfg(0, 16'h0010, 16'h0040, 16'd3, 1'b1, "c3");
    wait_done(0, 13, 0, 0, "c3");
    chk("c3_mem40", sram[16'h0040], 32'h5A00_0010);
    chk("c3_mem41", sram[16'h0041], 32'h5A00_0011);
    chk("c3_mem42", sram[16'h0042], 32'h5A00_0012);

    // Two channels interleave ch0, ch1, ch0, ch1.
    push_wr(16'h0060, 32'h5A00_0020);
    push_wr(16'h0070, 32'h5A00_0030);
    push_wr(16'h0061, 32'h5A00_0021);
    push_wr(16'h0071, 32'h5A00_0031);
    do_cfg(0, 16'h0020, 16'h0060, 16'd2, 1'b1, "rr0");
    do_cfg(1, 16'h0030, 16'h0070, 16'd2, 1'b1, "rr1");
    n0 = -1; n1 = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk); #2;
      if (done[0] && n0 < 0) n0 = n;
      if (done[1] && n1 < 0) n1 = n;
    end
    chk("rr_done0_cyc", 32'(n0), 12);
    chk("rr_done1_cyc", 32'(n1), 16);

    // CPU contention: 5 stall cycles during RD delay the 1-word copy by 5.
    push_wr(16'h00A0, 32'h5A00_0080);
    do_cfg(0, 16'h0080, 16'h00A0, 16'd1, 1'b1, "stall");
    wait_done(0, 10, 2, 7, "stall");

    // Source address wrap and poll_len progression.
    poll_ch = '0;
    push_wr(16'h0100, 32'h5A00_FFFF);
    push_wr(16'h0101, 32'h5A00_0000);
    do_cfg(0, 16'hFFFF, 16'h0100, 16'd2, 1'b1, "wrap");
    wait_done(0, 9, 0, 0, "wrap");
    chk("wrap_poll1", 32'(plen[1]), 2);
    chk("wrap_poll5", 32'(plen[5]), 1);
    chk("wrap_poll9", 32'(plen[9]), 0);

    // Zero-length request.
    do_cfg(1, 16'h0500, 16'h0600, 16'd0, 1'b1, "len0");
    @(negedge clk); #2;
    chk("len0_done", 32'(done[1]), 1);
    chk("len0_busy", 32'(busy[1]), 0);
    @(negedge clk); #2;
    chk("len0_done_off", 32'(done[1]), 0);

    // Request to a busy channel is refused and leaves its descriptor intact.
    push_wr(16'h0300, 32'h5A00_0200);
    push_wr(16'h0301, 32'h5A00_0201);
    do_cfg(0, 16'h0200, 16'h0300, 16'd2, 1'b1, "bz_a");
    do_cfg(0, 16'h0999, 16'h0999, 16'd5, 1'b0, "bz_b");
    @(negedge clk); #2;
    chk("bz_poll", 32'(poll_len), 2);
    chk("bz_busy", 32'(busy[0]), 1);
    wait_done(0, 7, 0, 0, "bz");

    // Reset mid-copy: len 4, reset once 2 words remain.
    push_wr(16'h0500, 32'h5A00_0400);
    push_wr(16'h0501, 32'h5A00_0401);
    do_cfg(0, 16'h0400, 16'h0500, 16'd4, 1'b1, "rst");
    repeat (9) begin
      @(negedge clk); #2;
    end
    chk("rst_mid_poll", 32'(poll_len), 2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk); #2;
      if (mem_en || done != '0 || busy != '0 || poll_len != '0) bad++;
    end
    chk("rst_quiet_cycles", 32'(bad), 0);

`ifdef DMA_ENGINE_ABORT_EN
    // Abort during CAP of word 2: no write, busy gone the next cycle.
    push_wr(16'h0700, 32'h5A00_0600);
    do_cfg(0, 16'h0600, 16'h0700, 16'd3, 1'b1, "abt");
    bad = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      abort_valid = (n == 7);
      abort_ch = '0;
      #2;
      if (done[0]) bad++;
    end
    chk("abt_busy", 32'(busy[0]), 0);
    chk("abt_poll", 32'(poll_len), 0);
    repeat (10) begin
      @(negedge clk); #2;
      if (done[0] || mem_en) bad++;
    end
    chk("abt_quiet", 32'(bad), 0);
`endif

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
